// File: rtl/ycbcr_to_rgb_pipe.sv
// ycbcr_to_rgb_pipe
//   Three-stage BT.601 studio-swing YCbCr -> RGB converter. Coefficients are
//   scaled by 256. The result is rounded (+128, >>>8) and saturated to 0..255.
//   A sideband word rides along with each pixel.
//   The whole pipe advances together on en = iReady | ~oValid. While the output
//   is stalled, nothing moves, and bubbles already in the pipe are kept.
// Ports:
//   iClk, iRst_n             clock, async active-low reset
//   iY/iCb/iCr/iSb, iValid   input pixel + sideband, valid
//   oReady                   pipe can accept input (== en)
//   oR/oG/oB/oSb, oValid     registered output pixel + sideband, valid
//   iReady                   downstream accepts output
module ycbcr_to_rgb_pipe #(
   parameter int SB_W = 2
) (
   input  logic            iClk,
   input  logic            iRst_n,
   input  logic [7:0]      iY,
   input  logic [7:0]      iCb,
   input  logic [7:0]      iCr,
   input  logic [SB_W-1:0] iSb,
   input  logic            iValid,
   output logic            oReady,
   output logic [7:0]      oR,
   output logic [7:0]      oG,
   output logic [7:0]      oB,
   output logic [SB_W-1:0] oSb,
   output logic            oValid,
   input  logic            iReady
);
   localparam int STAGES = 3;

   // stage 1: signed offsets
   typedef struct packed {
      logic signed [8:0] yo;
      logic signed [8:0] cbo;
      logic signed [8:0] cro;
   } s1_t;

   // stage 2: x256 products
   typedef struct packed {
      logic signed [19:0] py;
      logic signed [19:0] prc;
      logic signed [19:0] pgc;
      logic signed [19:0] pgr;
      logic signed [19:0] pbc;
   } s2_t;

   logic [STAGES:1]  vld_pipe;
   logic [SB_W-1:0]  sb1, sb2;
   s1_t              s1;
   s2_t              s2;
   logic             en;
   logic signed [19:0] r_sum, g_sum, b_sum;

   assign en     = iReady | ~oValid;
   assign oReady = en;
   assign oValid = vld_pipe[STAGES];

   // Round to nearest and clamp to 0..255. The 20-bit sum range cannot overflow.
   function automatic logic [7:0] sat8(input logic signed [19:0] s);
      logic signed [19:0] r;
      r = (s + 20'sd128) >>> 8;
      if (r < 20'sd0)        return 8'd0;
      else if (r > 20'sd255) return 8'd255;
      else                   return r[7:0];
   endfunction

   assign r_sum = s2.py + s2.prc;
   assign g_sum = s2.py - s2.pgc - s2.pgr;
   assign b_sum = s2.py + s2.pbc;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         vld_pipe <= '0;
         s1       <= '0;
         s2       <= '0;
         sb1      <= '0;
         sb2      <= '0;
         oSb      <= '0;
         oR       <= '0;
         oG       <= '0;
         oB       <= '0;
      end else if (en) begin
         // A bubble enters when iValid is low.
         vld_pipe <= {vld_pipe[STAGES-1:1], iValid};

         s1.yo  <= {1'b0, iY}  - 9'd16;
         s1.cbo <= {1'b0, iCb} - 9'd128;
         s1.cro <= {1'b0, iCr} - 9'd128;
         sb1    <= iSb;

         s2.py  <= 20'(s1.yo)  * 20'sd298;
         s2.prc <= 20'(s1.cro) * 20'sd409;
         s2.pgc <= 20'(s1.cbo) * 20'sd100;
         s2.pgr <= 20'(s1.cro) * 20'sd208;
         s2.pbc <= 20'(s1.cbo) * 20'sd516;
         sb2    <= sb1;

         oR  <= sat8(r_sum);
         oG  <= sat8(g_sum);
         oB  <= sat8(b_sum);
         oSb <= sb2;
      end
   end
endmodule

// File: tb/tb_ycbcr_to_rgb_pipe.sv
module tb_ycbcr_to_rgb_pipe;
   logic       iClk = 1'b0;
   logic       iRst_n;
   logic [7:0] iY, iCb, iCr;
   logic [1:0] iSb;
   logic       iValid, iReady;
   logic       oReady, oValid;
   logic [7:0] oR, oG, oB;
   logic [1:0] oSb;

   ycbcr_to_rgb_pipe #(.SB_W(2)) dut (
      .iClk(iClk), .iRst_n(iRst_n), .iY(iY), .iCb(iCb), .iCr(iCr), .iSb(iSb),
      .iValid(iValid), .oReady(oReady), .oR(oR), .oG(oG), .oB(oB), .oSb(oSb),
      .oValid(oValid), .iReady(iReady)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [7:0] r, g, b;
      logic [1:0] sb;
      int         tin;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;
   int   sent   = 0;
   bit   chk_lat = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] clamp(input int v);
      int t;
      t = (v + 128) >>> 8;
      if (t < 0) return 8'd0;
      if (t > 255) return 8'd255;
      return t[7:0];
   endfunction

   // Golden conversion from the integer formulas.
   function automatic exp_t model(input int y, input int cb, input int cr, input logic [1:0] sb);
      exp_t e;
      int yy, cbb, crr;
      yy = 298 * (y - 16); cbb = cb - 128; crr = cr - 128;
      e.r = clamp(yy + 409 * crr);
      e.g = clamp(yy - 100 * cbb - 208 * crr);
      e.b = clamp(yy + 516 * cbb);
      e.sb = sb;
      e.tin = 0;
      return e;
   endfunction

   // One clock: drive, check pre-edge (handshake, output transfer), clock, check hold.
   task automatic step(input logic v, input logic [7:0] y, cb, cr, input logic [1:0] sb,
                       input logic rdy, input bit hand, input logic [7:0] er, eg, eb);
      logic in_x, out_x, stall;
      logic [7:0] pr, pg, pb;
      logic [1:0] psb;
      exp_t e;
      iValid = v; iY = y; iCb = cb; iCr = cr; iSb = sb; iReady = rdy;
      #3;
      chk("oready", oReady, !(oValid && !iReady));
      in_x  = iValid && oReady;
      out_x = oValid && iReady;
      stall = oValid && !iReady;
      pr = oR; pg = oG; pb = oB; psb = oSb;
      if (out_x) begin
         chk("out_pending", q.size() != 0, 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("r", oR, e.r);
            chk("g", oG, e.g);
            chk("b", oB, e.b);
            chk("sb", oSb, e.sb);
            if (chk_lat) chk("latency", cyc_n - e.tin, 3);
         end
      end
      if (in_x) begin
         e = model(y, cb, cr, sb);
         if (hand) begin e.r = er; e.g = eg; e.b = eb; end
         e.tin = cyc_n;
         q.push_back(e);
         sent++;
      end
      @(posedge iClk);
      #1;
      cyc_n++;
      if (stall) begin
         chk("hold_v", oValid, 1);
         chk("hold_rgb", {oR, oG, oB, oSb}, {pr, pg, pb, psb});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic hand_px(input logic [7:0] y, cb, cr, input logic [1:0] sb, input logic [7:0] er, eg, eb);
      step(1'b1, y, cb, cr, sb, 1'b1, 1'b1, er, eg, eb);
      idle(4);
   endtask

   initial begin
      iRst_n = 1'b0; iValid = 1'b0; iReady = 1'b1;
      iY = '0; iCb = '0; iCr = '0; iSb = '0;
      #3;
      chk("rst_ovalid", oValid, 0);
      chk("rst_rgb", {oR, oG, oB}, 24'd0);
      chk("rst_sb", oSb, 0);
      chk("rst_oready", oReady, 1);
      #5 iRst_n = 1'b1;
      @(posedge iClk); #1;

      // Directed vectors, expectations worked out by hand.
      chk_lat = 1'b1;
      hand_px(8'd16,  8'd128, 8'd128, 2'd1, 8'd0,   8'd0,   8'd0);    // black
      hand_px(8'd235, 8'd128, 8'd128, 2'd2, 8'd255, 8'd255, 8'd255);  // white
      hand_px(8'd81,  8'd90,  8'd240, 2'd3, 8'd255, 8'd0,   8'd0);    // red, B = -1 clamps
      hand_px(8'd255, 8'd255, 8'd255, 2'd0, 8'd255, 8'd125, 8'd255);
      hand_px(8'd0,   8'd0,   8'd0,   2'd1, 8'd0,   8'd135, 8'd0);
      chk("directed_drained", q.size(), 0);

      // Back-to-back streaming, one per cycle.
      for (int i = 0; i < 64; i++)
         step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      idle(4);
      chk("stream_drained", q.size(), 0);

      // Random backpressure and input gaps.
      chk_lat = 1'b0;
      sent = 0;
      for (int i = 0; i < 5000 && sent < 500; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
              1'($urandom_range(0, 2) != 0), 1'b0, 8'd0, 8'd0, 8'd0);
      chk("bp_sent", sent, 500);
      for (int i = 0; i < 40 && q.size() != 0; i++) idle(1);
      chk("bp_drained", q.size(), 0);

      // Reset with three pixels in flight.
      chk_lat = 1'b1;
      for (int i = 0; i < 3; i++)
         step(1'b1, 8'd200, 8'd60, 8'd180, 2'd3, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      chk("pre_rst_ovalid", oValid, 1);
      iValid = 1'b0;
      iRst_n = 1'b0;
      #2;
      chk("mid_rst_ovalid", oValid, 0);
      chk("mid_rst_rgb", {oR, oG, oB, oSb}, 26'd0);
      q.delete();
      iRst_n = 1'b1;
      @(posedge iClk); #1;
      cyc_n++;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         chk("no_stale", oValid, 0);
      end
      hand_px(8'd81, 8'd90, 8'd240, 2'd2, 8'd255, 8'd0, 8'd0);
      chk("post_rst_drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
